// File: rtl/alu_result_buffer.sv
// Result buffer behind the signed ALU: converts sign-magnitude results to two's
// complement, recomputes SF/ZF, queues them in a FIFO and keeps sticky status bits.
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_r,
    input  logic          in_sf,
    input  logic          in_zf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    out_data,
    output logic          out_sf,
    output logic          out_zf,
    output logic [CW-1:0] count,
    input  logic          clr_sticky,
    output logic          neg_seen,
    output logic          zero_seen
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry layout: {data[4:0], sf, zf}. Magnitude zero always maps to +0.
    function automatic logic [6:0] to_twos(input logic [4:0] r);
        logic [4:0] data;
        logic       sf;
        logic       zf;
        if (r[3:0] == 4'd0) begin
            data = 5'd0;
            sf   = 1'b0;
            zf   = 1'b1;
        end else if (r[4] == 1'b0) begin
            data = {1'b0, r[3:0]};
            sf   = 1'b0;
            zf   = 1'b0;
        end else begin
            data = (~{1'b0, r[3:0]}) + 5'd1;
            sf   = 1'b1;
            zf   = 1'b0;
        end
        return {data, sf, zf};
    endfunction

    logic [6:0]    mem_q [DEPTH];
    logic [6:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          neg_seen_q, neg_seen_d;
    logic          zero_seen_q, zero_seen_d;

    logic [6:0]    conv_s;
    logic          push_s;
    logic          pop_s;
    logic          unused_flags_s;

    assign unused_flags_s = in_sf ^ in_zf;

    // Handshake and output view, all derived from registered state.
    always_comb begin
        conv_s    = to_twos(in_r);
        in_ready  = (count_q < CW'(DEPTH));
        out_valid = (count_q != CW'(0));
        push_s    = in_valid & in_ready;
        pop_s     = out_valid & out_ready;
        count     = count_q;
        neg_seen  = neg_seen_q;
        zero_seen = zero_seen_q;
        if (out_valid) begin
            {out_data, out_sf, out_zf} = mem_q[rd_ptr_q];
        end else begin
            {out_data, out_sf, out_zf} = 7'd0;
        end
    end

    // Next-state for storage, pointers, occupancy and sticky status.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        neg_seen_d  = neg_seen_q;
        zero_seen_d = zero_seen_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = conv_s;
            wr_ptr_d        = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        // Clear first so that a same-cycle setting push takes priority.
        if (clr_sticky) begin
            neg_seen_d  = 1'b0;
            zero_seen_d = 1'b0;
        end else begin
            neg_seen_d  = neg_seen_q;
            zero_seen_d = zero_seen_q;
        end
        if (push_s && conv_s[1]) begin
            neg_seen_d = 1'b1;
        end else begin
            neg_seen_d = neg_seen_d;
        end
        if (push_s && conv_s[0]) begin
            zero_seen_d = 1'b1;
        end else begin
            zero_seen_d = zero_seen_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 7'd0;
            end
            wr_ptr_q    <= PW'(1'b0);
            rd_ptr_q    <= PW'(1'b0);
            count_q     <= CW'(1'b0);
            neg_seen_q  <= 1'b0;
            zero_seen_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            neg_seen_q  <= neg_seen_d;
            zero_seen_q <= zero_seen_d;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: random and directed stimulus,
// queue-based reference model, negedge monitor comparing against it.
module tb_alu_result_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_r;
    logic       in_sf;
    logic       in_zf;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       out_sf;
    logic       out_zf;
    logic [2:0] count;
    logic       clr_sticky;
    logic       neg_seen;
    logic       zero_seen;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [6:0] sbq [$];
    logic       m_neg    = 1'b0;
    logic       m_zero   = 1'b0;
    logic       started  = 1'b0;
    logic       pend_pop = 1'b0;
    logic [6:0] rec_e;
    logic       rec_full;

    alu_result_buffer #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r),
        .in_sf(in_sf), .in_zf(in_zf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sf(out_sf), .out_zf(out_zf),
        .count(count), .clr_sticky(clr_sticky),
        .neg_seen(neg_seen), .zero_seen(zero_seen)
    );

    always #5 clk = ~clk;

    // Reference conversion using signed integer arithmetic.
    function automatic logic [6:0] ref_conv(input logic [4:0] r);
        int v;
        logic [4:0] d;
        v = r[4] ? -int'(r[3:0]) : int'(r[3:0]);
        d = v[4:0];
        return {d, (v < 0), (v == 0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model update on the active edge: pops decided by the monitor, then pushes.
    always @(posedge clk) begin
        if (rst) begin
            sbq.delete();
            m_neg    = 1'b0;
            m_zero   = 1'b0;
            pend_pop = 1'b0;
            started  = 1'b1;
        end else if (started) begin
            rec_full = (sbq.size() >= 4);
            if (pend_pop) void'(sbq.pop_front());
            pend_pop = 1'b0;
            if (clr_sticky) begin
                m_neg  = 1'b0;
                m_zero = 1'b0;
            end
            if (in_valid && !rec_full) begin
                rec_e = ref_conv(in_r);
                sbq.push_back(rec_e);
                if (rec_e[1]) m_neg = 1'b1;
                if (rec_e[0]) m_zero = 1'b1;
            end
        end
    end

    // Monitor: compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("count", 32'(count), 32'(sbq.size()));
            chk("in_ready", 32'(in_ready), 32'(sbq.size() < 4));
            chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
            chk("neg_seen", 32'(neg_seen), 32'(m_neg));
            chk("zero_seen", 32'(zero_seen), 32'(m_zero));
            if (sbq.size() == 0) begin
                chk("idle_out", 32'({out_data, out_sf, out_zf}), 32'd0);
            end else begin
                chk("head", 32'({out_data, out_sf, out_zf}), 32'(sbq[0]));
                if (out_ready) pend_pop = 1'b1;
            end
        end
    end

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12 && count != 3'd0; i++) step();
        chk(name, 32'(count), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_r = 5'd0; in_sf = 1'b0; in_zf = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_count", 32'(count), 32'd0);

        // Conversion sweep with explicit expectations
        out_ready = 1'b1;
        in_valid = 1'b1; in_r = 5'b00101; step(); in_valid = 1'b0;
        chk("conv_pos", 32'({out_data, out_sf, out_zf}), 32'({5'b00101, 1'b0, 1'b0}));
        step();
        in_valid = 1'b1; in_r = 5'b10101; step(); in_valid = 1'b0;
        chk("conv_neg5", 32'({out_data, out_sf, out_zf}), 32'({5'b11011, 1'b1, 1'b0}));
        step();
        in_valid = 1'b1; in_r = 5'b11111; step(); in_valid = 1'b0;
        chk("conv_neg15", 32'({out_data, out_sf}), 32'({5'b10001, 1'b1}));
        step();
        in_valid = 1'b1; in_r = 5'b10000; step(); in_valid = 1'b0;
        chk("conv_negzero", 32'({out_data, out_sf, out_zf}), 32'({5'b00000, 1'b0, 1'b1}));
        step();

        // Fill to full, refuse a fifth push, then drain in order
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_r = 5'(i); step();
        end
        in_r = 5'd5;
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("full_refused", 32'(count), 32'd4);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("ready_after_pop", 32'(in_ready), 32'd1);
        drain("drain_full");

        // Simultaneous push and pop at count 2
        out_ready = 1'b0;
        in_valid = 1'b1; in_r = 5'b01001; step();
        in_r = 5'b11010; step();
        in_r = 5'b00011; out_ready = 1'b1; step();
        chk("pushpop_count", 32'(count), 32'd2);
        drain("drain_pushpop");

        // Random traffic with random consumer stalls
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_r      = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("drain_random");

        // Sticky bits
        clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
        in_valid = 1'b1; in_r = 5'b10011; step(); in_valid = 1'b0;
        chk("sticky_neg_set", 32'(neg_seen), 32'd1);
        clr_sticky = 1'b1; step(); clr_sticky = 1'b0;
        chk("sticky_neg_clr", 32'(neg_seen), 32'd0);
        clr_sticky = 1'b1; in_valid = 1'b1; in_r = 5'b00000; step();
        clr_sticky = 1'b0; in_valid = 1'b0;
        chk("sticky_set_wins", 32'(zero_seen), 32'd1);
        drain("drain_sticky");

        // Reset with three entries held and an input presented
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_r = 5'(5'd17 + 5'(i)); step();
        end
        rst = 1'b1; in_valid = 1'b1; in_r = 5'd7; step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sticky", 32'({neg_seen, zero_seen}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("rst_input_dropped", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
